// File: rtl/apb_bridge_master.sv
// APB3 initiator: turns one valid/ready request into a single APB transfer and
// returns read data plus error/timeout status on a valid/ready response channel.
module apb_bridge_master #(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WRITE,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ_WDATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_RDATA,
  output logic                  RSP_ERR,
  output logic                  RSP_TIMEOUT,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  localparam bit        TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [7:0] WAIT_LAST = (TIMEOUT_CYCLES == 0) ? 8'd0 : 8'(TIMEOUT_CYCLES - 1);

  state_t     state_reg;
  logic [7:0] wait_cnt_reg;
  logic       timeout_hit;

  // The abort fires on the last allowed wait cycle; PREADY is checked first so it still wins.
  assign timeout_hit = TIMEOUT_EN && (wait_cnt_reg == WAIT_LAST);
  assign REQ_READY   = (state_reg == ST_IDLE);

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= 8'd0;
      PSEL         <= 1'b0;
      PENABLE      <= 1'b0;
      PWRITE       <= 1'b0;
      PADDR        <= '0;
      PWDATA       <= '0;
      RSP_VALID    <= 1'b0;
      RSP_RDATA    <= '0;
      RSP_ERR      <= 1'b0;
      RSP_TIMEOUT  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          if (REQ_VALID) begin
            PWRITE       <= REQ_WRITE;
            PADDR        <= REQ_ADDR;
            PWDATA       <= REQ_WDATA;
            wait_cnt_reg <= 8'd0;
            PSEL         <= 1'b1;
            state_reg    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          PENABLE   <= 1'b1;
          state_reg <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            RSP_RDATA   <= PWRITE ? '0 : PRDATA;
            RSP_ERR     <= PSLVERR;
            RSP_TIMEOUT <= 1'b0;
            RSP_VALID   <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            state_reg   <= ST_RESP;
          end else if (timeout_hit) begin
            RSP_RDATA   <= '0;
            RSP_ERR     <= 1'b1;
            RSP_TIMEOUT <= 1'b1;
            RSP_VALID   <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            state_reg   <= ST_RESP;
          end else if (wait_cnt_reg != 8'hFF) begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        ST_RESP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_bridge_master.sv
// Bench for apb_bridge_master: a behavioural APB slave with configurable wait states,
// and a per-transaction model of latency, enable length and response fields.
module tb_apb_bridge_master;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESETN = 1'b0;
  logic          REQ_VALID = 1'b0;
  logic          REQ_READY;
  logic          REQ_WRITE = 1'b0;
  logic [AW-1:0] REQ_ADDR = '0;
  logic [DW-1:0] REQ_WDATA = '0;
  logic          RSP_VALID;
  logic          RSP_READY = 1'b0;
  logic [DW-1:0] RSP_RDATA;
  logic          RSP_ERR;
  logic          RSP_TIMEOUT;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA = '0;
  logic          PREADY = 1'b0;
  logic          PSLVERR = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  // slave configuration
  int            s_waits = 0;
  logic          s_err = 1'b0;
  logic [DW-1:0] s_rdata = '0;
  int            s_acc = 0;

  apb_bridge_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
    .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // Slave: PREADY rises on ACCESS cycle number s_waits (0-based); PSLVERR only with PREADY.
  always @(negedge PCLK) begin
    if (PSEL && PENABLE) begin
      PREADY  = (s_acc == s_waits);
      PSLVERR = PREADY & s_err;
      s_acc   = s_acc + 1;
    end else begin
      s_acc   = 0;
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
    end
    PRDATA = s_rdata;
  end

  task automatic do_txn(input string name, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input int waits, input logic err,
                        input logic [DW-1:0] rd, input int rsp_delay, input bit early);
    bit            tmo;
    int            acc, en_cnt, rsp_cyc;
    bit            unstable;
    logic [DW+1:0] exp_rsp, act_rsp;
    tmo     = (TO != 0) && (waits >= TO);
    acc     = tmo ? TO : waits + 1;
    exp_rsp = {(tmo || w) ? {DW{1'b0}} : rd, tmo | err, tmo};
    s_waits = waits; s_err = err; s_rdata = rd;
    en_cnt = 0; rsp_cyc = -1; unstable = 0;

    @(negedge PCLK);
    RSP_READY = early;
    REQ_VALID = 1'b1; REQ_WRITE = w; REQ_ADDR = a; REQ_WDATA = wd;
    n_cmp++;
    if (REQ_READY !== 1'b1) begin
      n_err++; $display("FAIL %s req_ready_idle: got %b want 1", name, REQ_READY);
    end
    @(posedge PCLK); #1;
    REQ_VALID = 1'b0;
    for (int cyc = 1; cyc <= 300 && rsp_cyc < 0; cyc++) begin
      @(negedge PCLK);
      if (cyc == 1) begin
        n_cmp++;
        if ({PSEL, PENABLE} !== 2'b10) begin
          n_err++; $display("FAIL %s setup_phase: psel/penable=%b want 10", name, {PSEL, PENABLE});
        end
      end
      if (PENABLE === 1'b1) begin
        en_cnt++;
        if (PSEL !== 1'b1 || PADDR !== a || PWRITE !== w || PWDATA !== wd) unstable = 1;
      end
      if (RSP_VALID === 1'b1) rsp_cyc = cyc;
    end
    n_cmp++;
    if (rsp_cyc != 2 + acc) begin
      n_err++; $display("FAIL %s rsp_latency: got %0d want %0d", name, rsp_cyc, 2 + acc);
    end
    if (rsp_cyc < 0) return;
    n_cmp++;
    if (en_cnt != acc) begin
      n_err++; $display("FAIL %s penable_cycles: got %0d want %0d", name, en_cnt, acc);
    end
    n_cmp++;
    if (unstable) begin
      n_err++; $display("FAIL %s apb_stable: got unstable want addr=%h wr=%b wd=%h", name, a, w, wd);
    end
    n_cmp++;
    if ({PSEL, PENABLE} !== 2'b00) begin
      n_err++; $display("FAIL %s apb_release: psel/penable=%b want 00", name, {PSEL, PENABLE});
    end
    act_rsp = {RSP_RDATA, RSP_ERR, RSP_TIMEOUT};
    n_cmp++;
    if (act_rsp !== exp_rsp) begin
      n_err++; $display("FAIL %s rsp_fields: got rdata=%h err=%b to=%b want rdata=%h err=%b to=%b",
                        name, act_rsp[DW+1:2], act_rsp[1], act_rsp[0], exp_rsp[DW+1:2], exp_rsp[1], exp_rsp[0]);
    end
    if (!early) begin
      for (int d = 0; d < rsp_delay; d++) begin
        @(negedge PCLK);
        n_cmp++;
        if ({RSP_VALID, REQ_READY, RSP_RDATA, RSP_ERR, RSP_TIMEOUT} !== {1'b1, 1'b0, exp_rsp}) begin
          n_err++; $display("FAIL %s rsp_hold[%0d]: got valid=%b req_ready=%b rsp=%h want 1 0 %h",
                            name, d, RSP_VALID, REQ_READY, {RSP_RDATA, RSP_ERR, RSP_TIMEOUT}, exp_rsp);
        end
      end
      RSP_READY = 1'b1;
    end
    @(negedge PCLK);
    RSP_READY = 1'b0;
    n_cmp++;
    if ({RSP_VALID, REQ_READY} !== 2'b01) begin
      n_err++; $display("FAIL %s after_handshake: valid/req_ready=%b want 01", name, {RSP_VALID, REQ_READY});
    end
    $display("txn %s: wr=%b addr=%h wd=%h waits=%0d err=%b -> rdata=%h err=%b to=%b lat=%0d",
             name, w, a, wd, waits, err, RSP_RDATA, RSP_ERR, RSP_TIMEOUT, rsp_cyc);
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({PSEL, PENABLE, PWRITE, RSP_VALID, RSP_ERR, RSP_TIMEOUT, PADDR, PWDATA, RSP_RDATA} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %b want all zero",
                        {PSEL, PENABLE, PWRITE, RSP_VALID, RSP_ERR, RSP_TIMEOUT, PADDR, PWDATA, RSP_RDATA});
    end
    n_cmp++;
    if (REQ_READY !== 1'b1) begin
      n_err++; $display("FAIL reset_req_ready: got %b want 1", REQ_READY);
    end
    @(negedge PCLK);
    PRESETN = 1'b1;
    $display("txn reset: released");
  endtask

  task automatic test_write_zero_wait();
    do_txn("write_5a", 1'b1, 5'h00, 8'h5A, 0, 1'b0, 8'hEE, 0, 1'b0);
  endtask

  task automatic test_read_wait_states();
    do_txn("read_wait3", 1'b0, 5'h04, 8'h00, 3, 1'b0, 8'hC3, 0, 1'b0);
  endtask

  task automatic test_slave_error();
    do_txn("read_slverr", 1'b0, 5'h08, 8'h00, 1, 1'b1, 8'h96, 0, 1'b0);
  endtask

  task automatic test_timeout();
    do_txn("timeout_stuck", 1'b0, 5'h0C, 8'h00, 200, 1'b0, 8'hAB, 0, 1'b0);
    do_txn("timeout_edge_ready", 1'b0, 5'h0D, 8'h00, TO - 1, 1'b0, 8'h3C, 0, 1'b0);
    do_txn("timeout_exact", 1'b1, 5'h0E, 8'h11, TO, 1'b0, 8'h3C, 0, 1'b0);
  endtask

  task automatic test_rsp_backpressure();
    do_txn("rsp_hold5", 1'b0, 5'h10, 8'h00, 0, 1'b0, 8'h77, 5, 1'b0);
    do_txn("after_hold", 1'b1, 5'h11, 8'h22, 0, 1'b0, 8'h00, 0, 1'b0);
    do_txn("rsp_ready_early", 1'b0, 5'h12, 8'h00, 2, 1'b0, 8'h81, 0, 1'b1);
  endtask

  task automatic test_idle_hold();
    repeat (3) @(negedge PCLK);
    n_cmp++;
    if ({PSEL, PENABLE, PADDR, PWRITE, PWDATA} !== {2'b00, 5'h12, 1'b0, 8'h00}) begin
      n_err++; $display("FAIL idle_hold: got psel=%b pen=%b addr=%h wr=%b wd=%h want 0 0 12 0 00",
                        PSEL, PENABLE, PADDR, PWRITE, PWDATA);
    end
    $display("txn idle_hold: addr=%h", PADDR);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      int r, waits;
      r = $urandom_range(0, 9);
      case (r)
        6: waits = TO - 2;
        7: waits = TO - 1;
        8: waits = TO;
        9: waits = TO + $urandom_range(1, 20);
        default: waits = r % 4;
      endcase
      do_txn($sformatf("rand%0d", i), 1'($urandom), 5'($urandom), 8'($urandom), waits,
             1'($urandom), 8'($urandom), $urandom_range(0, 4), 1'($urandom_range(0, 3) == 0));
    end
  endtask

  task automatic test_reset_mid_access();
    bit seen;
    seen = 0;
    s_waits = 1000; s_err = 1'b0; s_rdata = 8'h5F;
    @(negedge PCLK);
    REQ_VALID = 1'b1; REQ_WRITE = 1'b0; REQ_ADDR = 5'h04; REQ_WDATA = 8'h00;
    @(posedge PCLK); #1;
    REQ_VALID = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge PCLK);
      if (PENABLE === 1'b1) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++; $display("FAIL rst_mid_reach_access: got no access want penable=1");
    end
    @(posedge PCLK); #1;
    @(posedge PCLK); #2;
    PRESETN = 1'b0;
    #1;
    n_cmp++;
    if ({PSEL, PENABLE, RSP_VALID} !== 3'b000) begin
      n_err++; $display("FAIL rst_mid_async: psel/pen/valid=%b want 000", {PSEL, PENABLE, RSP_VALID});
    end
    @(negedge PCLK);
    PRESETN = 1'b1;
    s_waits = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge PCLK);
      n_cmp++;
      if ({REQ_READY, PSEL, RSP_VALID} !== 3'b100) begin
        n_err++; $display("FAIL rst_mid_idle[%0d]: req_ready/psel/valid=%b want 100",
                          c, {REQ_READY, PSEL, RSP_VALID});
      end
    end
    $display("txn reset_mid_access: recovered");
    do_txn("post_reset", 1'b0, 5'h1F, 8'h00, 0, 1'b0, 8'hA5, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait_states();
    test_slave_error();
    test_timeout();
    test_rsp_backpressure();
    test_idle_hold();
    test_random();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_bridge_master.md
Name: apb_bridge_master

Overview:
- Hardware APB3 initiator. Converts a simple valid/ready request channel into single APB transactions, then returns read data and status on a valid/ready response channel.
- Lets on-chip logic drive CoreUARTapb (and other APB slaves) the way the APB master BFM does in simulation, but in synthesizable RTL.
- Sits between a local command source (sequencer or CPU-side adapter) and the APB slave select/mux.
- Adds PREADY wait-state handling, PSLVERR capture and a bus timeout.

Parameters:
- ADDR_WIDTH, 5, width of REQ_ADDR and PADDR (5 matches the CoreUARTapb register map).
- DATA_WIDTH, 8, width of write/read data.
- TIMEOUT_CYCLES, 16, maximum ACCESS-phase wait cycles with PREADY low before abort. 0 disables the timeout. Legal range 0..255.

Ports:
- PCLK  in  1  system/APB clock, rising edge.
- PRESETN  in  1  asynchronous active-low reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  bridge accepts request (high only in IDLE).
- REQ_WRITE  in  1  1=write, 0=read.
- REQ_ADDR  in  ADDR_WIDTH  target address.
- REQ_WDATA  in  DATA_WIDTH  write data.
- RSP_VALID  out  1  response available.
- RSP_READY  in  1  consumer takes response.
- RSP_RDATA  out  DATA_WIDTH  read data (0 for writes and timeouts).
- RSP_ERR  out  1  PSLVERR seen or timeout.
- RSP_TIMEOUT  out  1  transaction aborted by timeout.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  slave ready; tie high for zero-wait slaves.
- PSLVERR  in  1  slave error.

Behaviour:
- Outputs are registered, except REQ_READY, which is decoded from state.
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE.
  - PSEL, PENABLE, PWRITE, RSP_VALID, RSP_ERR, RSP_TIMEOUT = 0.
  - PADDR, PWDATA, RSP_RDATA = 0.
  - Timeout counter = 0.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID: capture REQ_WRITE/ADDR/WDATA into PWRITE/PADDR/PWDATA, clear the counter, go to SETUP.
  - With REQ_VALID low, the bridge stays in IDLE and the APB outputs hold their last values with PSEL=0.
- SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PADDR/PWDATA/PWRITE stay stable throughout.
  - PREADY=1: RSP_RDATA = PWRITE ? 0 : PRDATA. RSP_ERR=PSLVERR, RSP_TIMEOUT=0. Drop PSEL and PENABLE next cycle, go to RESP.
  - PREADY=0 and TIMEOUT_CYCLES≠0 and counter==TIMEOUT_CYCLES-1: abort. RSP_RDATA=0, RSP_ERR=1, RSP_TIMEOUT=1. Drop PSEL/PENABLE, go to RESP.
  - PREADY=0 otherwise: counter +1 (8-bit, saturates at 255), stay in ACCESS.
  - PREADY=1 on the same cycle the timeout would fire: PREADY wins, normal completion.
- RESP:
  - RSP_VALID=1; RSP_* held stable until RSP_READY=1.
  - On the handshake: RSP_VALID=0 next cycle, go to IDLE.
  - RSP_READY high before RSP_VALID has no effect.
- Latency, zero-wait slave:
  - Request accepted at edge N.
  - SETUP in cycle N+1, ACCESS in cycle N+2.
  - RSP_VALID=1 in cycle N+3.
  - With RSP_READY held high, REQ_READY=1 in cycle N+4.
  - Minimum 4 cycles per transaction. Each PREADY-low cycle adds 1.
- Only one transaction is ever outstanding. There is no pipelining and no back-to-back APB without an IDLE cycle.
- Reset mid-transaction: PSEL/PENABLE drop immediately (async). No response is produced for the aborted request.

Test Plan:
- Write 0x5A to addr 0x00, PREADY=1:
  - PSEL rises 1 cycle after accept; PENABLE 1 cycle later with PWDATA=0x5A, PWRITE=1.
  - RSP_VALID 3 cycles after accept with RSP_ERR=0, RSP_RDATA=0x00.
- Read addr 0x04 with PRDATA=0xC3 and PREADY low for 3 ACCESS cycles: PENABLE high for 4 cycles, RSP_RDATA=0xC3, RSP_VALID 6 cycles after accept.
- Read with PSLVERR=1 at completion: RSP_ERR=1, RSP_TIMEOUT=0, RSP_RDATA=PRDATA.
- TIMEOUT_CYCLES=16, PREADY stuck low:
  - Abort after exactly 16 ACCESS cycles.
  - RSP_ERR=1, RSP_TIMEOUT=1, RSP_RDATA=0x00; PSEL=0 the following cycle.
- RSP_READY held low for 5 cycles after RSP_VALID:
  - Response fields stay stable; REQ_READY stays 0.
  - After the handshake, the next request is accepted in IDLE.
- PRESETN asserted during ACCESS: PSEL, PENABLE and RSP_VALID go 0 asynchronously. After release, state is IDLE and REQ_READY=1.
